// File: rtl/rep_code_pkg.sv
// Shared definitions for the repetition-coded link (transmitter and receiver).
package rep_code_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_e;

  localparam int   REP_DEFAULT = 3;
  localparam logic LINE_IDLE   = 1'b1;

endpackage

// File: rtl/rep_symbol_timer.sv
// Counts REP cycles per symbol and strobes o_symbol_end on the last one.
module rep_symbol_timer #(
  parameter int REP = 3
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_clear,
  output logic o_symbol_end
);

  localparam int CW = (REP > 1) ? $clog2(REP) : 1;

  logic [CW-1:0] r_rep_cnt;

  assign o_symbol_end = (r_rep_cnt == CW'(REP - 1));

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rep_cnt <= '0;
    end else if (i_clear || o_symbol_end) begin
      r_rep_cnt <= '0;
    end else begin
      r_rep_cnt <= r_rep_cnt + CW'(1);
    end
  end

endmodule

// File: rtl/rep_code_tx.sv
// Repetition-coded serial transmitter: START, DATA_W bits LSB first, STOP, each held REP cycles.
module rep_code_tx
  import rep_code_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int REP    = REP_DEFAULT
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              tx_out,
  output logic              tx_active,
  output logic              tx_done
);

  localparam int BW = (DATA_W > 1) ? $clog2(DATA_W) : 1;

  state_e            r_state, w_state_nxt;
  logic [DATA_W-1:0] r_shift, w_shift_nxt;
  logic [BW-1:0]     r_bit_cnt, w_bit_cnt_nxt;
  logic              r_tx_out, r_in_ready, r_tx_active, r_tx_done;
  logic              w_tx_out_nxt, w_tx_done_nxt;
  logic              w_symbol_end;

  rep_symbol_timer #(.REP(REP)) u_timer (
    .clk          (clk),
    .rst_n        (rst_n),
    .i_clear      (r_state == IDLE),
    .o_symbol_end (w_symbol_end)
  );

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    w_state_nxt   = r_state;
    w_shift_nxt   = r_shift;
    w_bit_cnt_nxt = r_bit_cnt;
    w_tx_done_nxt = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (in_valid && r_in_ready) begin
          w_shift_nxt   = in_data;
          w_bit_cnt_nxt = '0;
          w_state_nxt   = START;
        end
      end
      START: begin
        if (w_symbol_end) begin
          w_bit_cnt_nxt = '0;
          w_state_nxt   = DATA;
        end
      end
      DATA: begin
        if (w_symbol_end) begin
          w_shift_nxt = r_shift >> 1;
          if (r_bit_cnt == BW'(DATA_W - 1)) begin
            w_bit_cnt_nxt = '0;
            w_state_nxt   = STOP;
          end else begin
            w_bit_cnt_nxt = r_bit_cnt + BW'(1);
          end
        end
      end
      STOP: begin
        if (w_symbol_end) begin
          w_state_nxt   = IDLE;
          w_tx_done_nxt = 1'b1;
        end
      end
      default: w_state_nxt = IDLE;
    endcase

    // Line level is derived from the next state so tx_out can be a plain flop.
    unique case (w_state_nxt)
      START:   w_tx_out_nxt = 1'b0;
      DATA:    w_tx_out_nxt = w_shift_nxt[0];
      default: w_tx_out_nxt = LINE_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_shift     <= '0;
      r_bit_cnt   <= '0;
      r_tx_out    <= LINE_IDLE;
      r_in_ready  <= 1'b1;
      r_tx_active <= 1'b0;
      r_tx_done   <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_shift     <= w_shift_nxt;
      r_bit_cnt   <= w_bit_cnt_nxt;
      r_tx_out    <= w_tx_out_nxt;
      r_in_ready  <= (w_state_nxt == IDLE);
      r_tx_active <= (w_state_nxt != IDLE);
      r_tx_done   <= w_tx_done_nxt;
    end
  end

  assign in_ready  = r_in_ready;
  assign tx_out    = r_tx_out;
  assign tx_active = r_tx_active;
  assign tx_done   = r_tx_done;

endmodule

// File: tb/tb_rep_code_tx.sv
// Self-checking bench for rep_code_tx: frame-level scoreboard plus a 3-sample majority voter.
module tb_rep_code_tx;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] in_data;
  logic       in_valid;
  logic       in_ready, tx_out, tx_active, tx_done;

  logic [3:0] in_data5;
  logic       in_valid5;
  logic       in_ready5, tx_out5, tx_active5, tx_done5;

  always #5 clk = ~clk;

  rep_code_tx #(.DATA_W(8), .REP(3)) u_dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .tx_out    (tx_out),
    .tx_active (tx_active),
    .tx_done   (tx_done)
  );

  rep_code_tx #(.DATA_W(4), .REP(5)) u_dut5 (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_data   (in_data5),
    .in_valid  (in_valid5),
    .in_ready  (in_ready5),
    .tx_out    (tx_out5),
    .tx_active (tx_active5),
    .tx_done   (tx_done5)
  );

  int         checks = 0;
  int         errors = 0;
  int         cyc_no = 0;
  bit         exp_line[$];
  logic [7:0] exp_word[$];
  int         start_cyc[$];
  bit         exp5[$];
  bit         done_due = 1'b0;
  bit         last_idle = 1'b1;
  bit         flip_en = 1'b0;
  int         samp_idx = 0;
  int         ones = 0;
  logic [7:0] rec_word;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Expected line waveform of one REP=3, DATA_W=8 frame.
  task automatic push_frame(input logic [7:0] d);
    exp_word.push_back(d);
    repeat (3) exp_line.push_back(1'b0);
    for (int i = 0; i < 8; i++) repeat (3) exp_line.push_back(d[i]);
    repeat (3) exp_line.push_back(1'b1);
  endtask

  task automatic clear_model();
    exp_line.delete();
    exp_word.delete();
    samp_idx  = 0;
    ones      = 0;
    done_due  = 1'b0;
    last_idle = 1'b1;
  endtask

  // Advance one cycle and compare all outputs of the main DUT against the scoreboard.
  task automatic tick();
    bit   e;
    logic s;
    int   sym;
    @(negedge clk);
    cyc_no++;
    if (exp_line.size() > 0) begin
      e = exp_line.pop_front();
      if (samp_idx == 0) start_cyc.push_back(cyc_no);
      check("tx_out", 32'(tx_out), 32'(e));
      check("tx_active_busy", 32'(tx_active), 32'(1));
      check("in_ready_busy", 32'(in_ready), 32'(0));
      check("tx_done_busy", 32'(tx_done), 32'(0));
      s = tx_out;
      if (flip_en && ((samp_idx % 3) == ((samp_idx / 3) % 3))) s = ~s;
      if (s === 1'b1) ones++;
      if ((samp_idx % 3) == 2) begin
        sym = samp_idx / 3;
        if (sym >= 1 && sym <= 8) rec_word[sym-1] = (ones >= 2);
        ones = 0;
      end
      samp_idx++;
      if (exp_line.size() == 0) begin
        check("voter_word", 32'(rec_word), 32'(exp_word.pop_front()));
        samp_idx = 0;
        done_due = 1'b1;
      end
      last_idle = 1'b0;
    end else begin
      check("tx_out_idle", 32'(tx_out), 32'(1));
      check("tx_active_idle", 32'(tx_active), 32'(0));
      check("in_ready_idle", 32'(in_ready), 32'(1));
      check("tx_done", 32'(tx_done), 32'(done_due));
      done_due  = 1'b0;
      last_idle = 1'b1;
    end
  endtask

  // Drive one cycle of stimulus; a handshake is predicted when the last observed cycle was IDLE.
  task automatic cyc(input bit v, input logic [7:0] d);
    in_valid = v;
    in_data  = d;
    if (v && last_idle) push_frame(d);
    tick();
  endtask

  task automatic send(input logic [7:0] d);
    cyc(1'b1, d);
    repeat (31) cyc(1'b0, 8'h00);
  endtask

  task automatic drain();
    int guard = 0;
    in_valid = 1'b0;
    while (!(last_idle && exp_line.size() == 0) && guard < 200) begin
      cyc(1'b0, 8'h00);
      guard++;
    end
    check("drain_bound", 32'(guard < 200), 32'(1));
    cyc(1'b0, 8'h00);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] words [3];
    logic [3:0] d5;
    words[0] = 8'h00;
    words[1] = 8'hFF;
    words[2] = 8'h3C;

    rst_n = 1'b0; in_valid = 1'b0; in_data = '0; in_valid5 = 1'b0; in_data5 = '0;
    repeat (2) @(negedge clk);
    check("rst_tx_out", 32'(tx_out), 32'(1));
    check("rst_in_ready", 32'(in_ready), 32'(1));
    check("rst_tx_active", 32'(tx_active), 32'(0));
    check("rst_tx_done", 32'(tx_done), 32'(0));
    check("rst5_tx_out", 32'(tx_out5), 32'(1));
    rst_n = 1'b1;
    clear_model();
    repeat (2) cyc(1'b0, 8'h00);

    // Single frame: 30 line cycles then a tx_done pulse on cycle 31 after the handshake.
    send(8'hA5);

    // Majority voter, clean then with one corrupted sample per symbol.
    for (int f = 0; f < 2; f++) begin
      flip_en = (f == 1);
      for (int w = 0; w < 3; w++) send(words[w]);
    end
    flip_en = 1'b0;

    // Valid held with data changing every cycle; the second word is whatever is present at acceptance.
    cyc(1'b1, 8'h11);
    for (int i = 0; i < 45; i++) cyc(1'b1, 8'($urandom()));
    drain();

    // Back-to-back frames with valid held high.
    cyc(1'b1, 8'h01);
    repeat (40) cyc(1'b1, 8'h80);
    drain();
    check("b2b_period", 32'(start_cyc[$] - start_cyc[$-1]), 32'(31));

    // Reset asserted during bit 3 of 8'hA5.
    cyc(1'b1, 8'hA5);
    repeat (13) cyc(1'b0, 8'h00);
    #1 rst_n = 1'b0;
    #1;
    check("async_rst_tx_out", 32'(tx_out), 32'(1));
    check("async_rst_in_ready", 32'(in_ready), 32'(1));
    check("async_rst_tx_active", 32'(tx_active), 32'(0));
    check("async_rst_tx_done", 32'(tx_done), 32'(0));
    clear_model();
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) cyc(1'b0, 8'h00);
    send(8'h5A);

    // REP=5, DATA_W=4 instance.
    d5 = 4'b1001;
    repeat (5) exp5.push_back(1'b0);
    for (int i = 0; i < 4; i++) repeat (5) exp5.push_back(d5[i]);
    repeat (5) exp5.push_back(1'b1);
    check("p5_ready", 32'(in_ready5), 32'(1));
    in_valid5 = 1'b1;
    in_data5  = d5;
    cyc(1'b0, 8'h00);
    in_valid5 = 1'b0;
    in_data5  = 4'b0110;
    check("p5_frame_len", 32'(exp5.size()), 32'(30));
    for (int i = 0; i < 30; i++) begin
      check("p5_tx_out", 32'(tx_out5), 32'(exp5.pop_front()));
      check("p5_tx_active", 32'(tx_active5), 32'(1));
      cyc(1'b0, 8'h00);
    end
    check("p5_tx_out_end", 32'(tx_out5), 32'(1));
    check("p5_tx_active_end", 32'(tx_active5), 32'(0));
    check("p5_tx_done", 32'(tx_done5), 32'(1));
    cyc(1'b0, 8'h00);
    check("p5_tx_done_pulse", 32'(tx_done5), 32'(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
